a0_trace_capture: RTL and testbench

Downstream observer for the full CPU's `a0` result register. Every cycle it samples `a0`. Each time the value changes, it records the new value together with a cycle timestamp into an internal FIFO. A valid/ready port drains the FIFO to the display driver or testbench. No change event is ever silently lost: drops are counted and flagged.

---
 rtl/a0_trace_capture.sv | 121 ++++++++++++
 tb/tb_a0_trace_capture.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/a0_trace_capture.sv
// a0_trace_capture: watches the CPU a0 register, queues every observed change
// with a cycle timestamp in a show-ahead FIFO, and counts events it had to drop.
module a0_trace_capture #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int TS_WIDTH   = 16,
  parameter int DROP_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [DATA_WIDTH-1:0]     a0,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic [TS_WIDTH-1:0]       out_ts,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow,
  output logic [DROP_WIDTH-1:0]     drop_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = TS_WIDTH + DATA_WIDTH;

  localparam logic [PW-1:0]         PTR_ONE_C  = PW'(32'd1);
  localparam logic [CW-1:0]         CNT_ONE_C  = CW'(32'd1);
  localparam logic [CW-1:0]         CNT_FULL_C = CW'(DEPTH);
  localparam logic [TS_WIDTH-1:0]   TS_ONE_C   = TS_WIDTH'(32'd1);
  localparam logic [DROP_WIDTH-1:0] DROP_ONE_C = DROP_WIDTH'(32'd1);
  localparam logic [DROP_WIDTH-1:0] DROP_MAX_C = {DROP_WIDTH{1'b1}};

  logic [DATA_WIDTH-1:0] prev_a0_r;
  logic [TS_WIDTH-1:0]   cyc_r;
  logic [EW-1:0]         mem_r [DEPTH];
  logic [PW-1:0]         wr_ptr_r;
  logic [PW-1:0]         rd_ptr_r;
  logic [CW-1:0]         count_r;
  logic                  overflow_r;
  logic [DROP_WIDTH-1:0] drop_count_r;

  logic                  ev_s;
  logic                  pop_s;
  logic                  push_s;
  logic                  drop_s;
  logic [CW-1:0]         count_next_s;
  logic [EW-1:0]         head_s;

  // Event detection and push/pop/drop arbitration for the current cycle.
  always_comb begin
    ev_s         = 1'b0;
    pop_s        = 1'b0;
    push_s       = 1'b0;
    drop_s       = 1'b0;
    count_next_s = count_r;
    ev_s  = en && (a0 != prev_a0_r);
    // Empty FIFO never pops, so a same-cycle event cannot bypass to the consumer.
    pop_s = (count_r != {CW{1'b0}}) && out_ready;
    if (ev_s) begin
      // A simultaneous pop frees the slot even when full.
      push_s = (count_r < CNT_FULL_C) || pop_s;
      drop_s = (count_r == CNT_FULL_C) && !pop_s;
    end else begin
      push_s = 1'b0;
      drop_s = 1'b0;
    end
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_ONE_C;
      2'b01:   count_next_s = count_r - CNT_ONE_C;
      default: count_next_s = count_r;
    endcase
  end

  // Control state: sampled a0, timestamp counter, pointers, occupancy, drop tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_a0_r    <= {DATA_WIDTH{1'b0}};
      cyc_r        <= {TS_WIDTH{1'b0}};
      wr_ptr_r     <= {PW{1'b0}};
      rd_ptr_r     <= {PW{1'b0}};
      count_r      <= {CW{1'b0}};
      overflow_r   <= 1'b0;
      drop_count_r <= {DROP_WIDTH{1'b0}};
    end else begin
      prev_a0_r <= a0;
      cyc_r     <= cyc_r + TS_ONE_C;
      count_r   <= count_next_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
        if (drop_count_r != DROP_MAX_C) begin
          drop_count_r <= drop_count_r + DROP_ONE_C;
        end
      end
    end
  end

  // Entry storage; contents are only meaningful where count says so, so no reset.
  always_ff @(posedge clk) begin
    if (push_s && !rst) begin
      mem_r[wr_ptr_r] <= {cyc_r, a0};
    end
  end

  // Show-ahead head entry and status, all decoded from registered state.
  always_comb begin
    head_s     = mem_r[rd_ptr_r];
    out_data   = head_s[DATA_WIDTH-1:0];
    out_ts     = head_s[EW-1:DATA_WIDTH];
    out_valid  = (count_r != {CW{1'b0}});
    count      = count_r;
    overflow   = overflow_r;
    drop_count = drop_count_r;
  end

endmodule

// File: tb/tb_a0_trace_capture.sv
// Self-checking bench for a0_trace_capture: constant vector table, directed
// corner sequences, and randomized traffic against a queue-based model.
module tb_a0_trace_capture;

  logic        clk;
  logic        rst;
  logic        en;
  logic [31:0] a0;
  logic        out_ready;

  logic [31:0] out_data;
  logic [15:0] out_ts;
  logic        out_valid;
  logic [4:0]  count;
  logic        overflow;
  logic [7:0]  drop_count;

  logic [31:0] d4_data;
  logic [3:0]  d4_ts;
  logic        d4_valid;
  logic [4:0]  d4_count;
  logic        d4_overflow;
  logic [7:0]  d4_drop;

  a0_trace_capture dut (
    .clk(clk), .rst(rst), .en(en), .a0(a0),
    .out_data(out_data), .out_ts(out_ts), .out_valid(out_valid),
    .out_ready(out_ready), .count(count), .overflow(overflow),
    .drop_count(drop_count)
  );

  a0_trace_capture #(.TS_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .a0(a0),
    .out_data(d4_data), .out_ts(d4_ts), .out_valid(d4_valid),
    .out_ready(out_ready), .count(d4_count), .overflow(d4_overflow),
    .drop_count(d4_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: a plain queue of {timestamp, value} plus flags.
  typedef struct {
    int unsigned ts;
    logic [31:0] d;
  } ent_t;

  ent_t        mq[$];
  int unsigned m_cyc;
  logic [31:0] m_prev;
  logic        m_ovf;
  int unsigned m_drop;

  typedef struct {
    logic        r;
    logic        e;
    logic [31:0] a;
    logic        rd;
    logic        ev;
    logic [4:0]  ec;
    logic        eo;
    logic [31:0] ed;
    logic [15:0] et;
  } vec_t;

  vec_t tbl[$];

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic e, input logic [31:0] a, input logic rd);
    bit pop;
    ent_t n;
    if (r) begin
      mq.delete();
      m_cyc  = 0;
      m_prev = 32'd0;
      m_ovf  = 1'b0;
      m_drop = 0;
    end else begin
      pop = (mq.size() > 0) && rd;
      if (pop) void'(mq.pop_front());
      if (e && (a != m_prev)) begin
        if (mq.size() < 16) begin
          n.ts = m_cyc;
          n.d  = a;
          mq.push_back(n);
        end else begin
          m_ovf = 1'b1;
          if (m_drop < 255) m_drop++;
        end
      end
      m_prev = a;
      m_cyc++;
    end
  endtask

  task automatic check_model();
    cmp("m_valid", 64'(out_valid), 64'(mq.size() > 0));
    cmp("m_count", 64'(count), 64'(mq.size()));
    cmp("m_overflow", 64'(overflow), 64'(m_ovf));
    cmp("m_drop", 64'(drop_count), 64'(m_drop));
    cmp("m4_count", 64'(d4_count), 64'(mq.size()));
    if (mq.size() > 0) begin
      cmp("m_data", 64'(out_data), 64'(mq[0].d));
      cmp("m_ts", 64'(out_ts), 64'(mq[0].ts % 65536));
      cmp("m4_data", 64'(d4_data), 64'(mq[0].d));
      cmp("m4_ts", 64'(d4_ts), 64'(mq[0].ts % 16));
    end
  endtask

  // One clock cycle: drive inputs, advance model, sample after the edge.
  task automatic tick(input logic r, input logic e, input logic [31:0] a, input logic rd);
    rst       = r;
    en        = e;
    a0        = a;
    out_ready = rd;
    model_step(r, e, a, rd);
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic add(input logic r, input logic e, input logic [31:0] a, input logic rd,
                     input logic ev, input logic [4:0] ec, input logic eo,
                     input logic [31:0] ed, input logic [15:0] et);
    vec_t v;
    v = '{r, e, a, rd, ev, ec, eo, ed, et};
    tbl.push_back(v);
  endtask

  initial begin
    logic [15:0] last_ts;
    rst = 1'b1; en = 1'b0; a0 = 32'd0; out_ready = 1'b0;
    m_cyc = 0; m_prev = 32'd0; m_ovf = 1'b0; m_drop = 0;

    // Reset then idle.
    add(1'b1, 1'b1, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0, 16'd0);
    add(1'b1, 1'b1, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0, 16'd0);
    for (int i = 0; i < 10; i++)
      add(1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0, 16'd0);
    // Single change at cycle 5, held, then one-cycle ready pulse.
    add(1'b1, 1'b1, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0, 16'd0);
    for (int i = 0; i < 5; i++)
      add(1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0, 16'd0);
    for (int i = 5; i < 8; i++)
      add(1'b0, 1'b1, 32'h2A, 1'b0, 1'b1, 5'd1, 1'b0, 32'h2A, 16'd5);
    add(1'b0, 1'b1, 32'h2A, 1'b1, 1'b0, 5'd0, 1'b0, 32'd0, 16'd0);
    add(1'b0, 1'b1, 32'h2A, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0, 16'd0);
    // Enable gating: change while disabled is never reported.
    add(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0, 16'd0);
    for (int i = 0; i < 3; i++)
      add(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0, 16'd0);
    for (int i = 3; i < 6; i++)
      add(1'b0, 1'b0, 32'd7, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0, 16'd0);
    for (int i = 6; i < 9; i++)
      add(1'b0, 1'b1, 32'd7, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0, 16'd0);
    add(1'b0, 1'b1, 32'd8, 1'b0, 1'b1, 5'd1, 1'b0, 32'd8, 16'd9);
    add(1'b0, 1'b1, 32'd8, 1'b0, 1'b1, 5'd1, 1'b0, 32'd8, 16'd9);
    add(1'b0, 1'b1, 32'd8, 1'b1, 1'b0, 5'd0, 1'b0, 32'd0, 16'd0);

    foreach (tbl[k]) begin
      tick(tbl[k].r, tbl[k].e, tbl[k].a, tbl[k].rd);
      cmp("tbl_valid", 64'(out_valid), 64'(tbl[k].ev));
      cmp("tbl_count", 64'(count), 64'(tbl[k].ec));
      cmp("tbl_overflow", 64'(overflow), 64'(tbl[k].eo));
      if (tbl[k].ev) begin
        cmp("tbl_data", 64'(out_data), 64'(tbl[k].ed));
        cmp("tbl_ts", 64'(out_ts), 64'(tbl[k].et));
      end
    end

    // Fill past capacity, then push and pop in the same cycle while full.
    tick(1'b1, 1'b1, 32'd0, 1'b0);
    for (int i = 0; i < 20; i++) tick(1'b0, 1'b1, 32'(i + 1), 1'b0);
    cmp("fill_count", 64'(count), 64'd16);
    cmp("fill_overflow", 64'(overflow), 64'd1);
    cmp("fill_drop", 64'(drop_count), 64'd4);
    cmp("fill_head", 64'(out_data), 64'd1);
    tick(1'b0, 1'b1, 32'd100, 1'b1);
    cmp("full_pushpop_count", 64'(count), 64'd16);
    cmp("full_pushpop_head", 64'(out_data), 64'd2);
    cmp("full_pushpop_drop", 64'(drop_count), 64'd4);
    for (int i = 0; i < 15; i++) tick(1'b0, 1'b1, 32'd100, 1'b1);
    cmp("tail_count", 64'(count), 64'd1);
    cmp("tail_data", 64'(out_data), 64'd100);

    // Sustained push/pop with in-order delivery and 4-bit timestamp wrap.
    tick(1'b1, 1'b1, 32'd0, 1'b0);
    last_ts = 16'd0;
    for (int i = 0; i < 40; i++) begin
      tick(1'b0, 1'b1, 32'(i + 1), 1'b1);
      cmp("drain_count_le1", 64'(count <= 5'd1), 64'd1);
      cmp("drain_data", 64'(out_data), 64'(i + 1));
      if (i > 0) cmp("drain_ts_incr", 64'(out_ts > last_ts), 64'd1);
      last_ts = out_ts;
      if (i == 17) cmp("ts_wrap4", 64'(d4_ts), 64'd1);
    end

    // Reset mid-stream with entries buffered and overflow set.
    tick(1'b1, 1'b1, 32'd0, 1'b0);
    for (int i = 0; i < 20; i++) tick(1'b0, 1'b1, 32'(i + 1), 1'b0);
    for (int i = 0; i < 11; i++) tick(1'b0, 1'b1, 32'd20, 1'b1);
    cmp("pre_rst_count", 64'(count), 64'd5);
    cmp("pre_rst_overflow", 64'(overflow), 64'd1);
    tick(1'b1, 1'b1, 32'd20, 1'b0);
    cmp("rst_count", 64'(count), 64'd0);
    cmp("rst_valid", 64'(out_valid), 64'd0);
    cmp("rst_overflow", 64'(overflow), 64'd0);
    cmp("rst_drop", 64'(drop_count), 64'd0);
    tick(1'b0, 1'b1, 32'd20, 1'b0);
    cmp("post_rst_valid", 64'(out_valid), 64'd1);
    cmp("post_rst_ts", 64'(out_ts), 64'd0);
    cmp("post_rst_data", 64'(out_data), 64'd20);

    // Randomized traffic against the model.
    tick(1'b1, 1'b1, 32'd0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      tick(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 3) != 0),
           32'($urandom_range(0, 3)),
           ($urandom_range(0, 2) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
